// File: rtl/systolic_deskew.sv
// Re-aligns the skewed bottom-row column streams of the systolic mesh into row vectors
// and buffers them in a FIFO drained over valid/ready. Optional lane clamp: DESKEW_RELU_EN.
module systolic_deskew #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] col_data_in  [N],
  input  logic                         col_valid_in [N],
  output logic signed [DATA_WIDTH-1:0] out_data     [N],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow_err,
  output logic                         misalign_err,
  input  logic                         err_clear
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  function automatic logic signed [DATA_WIDTH-1:0] clamp_lane(
    input logic signed [DATA_WIDTH-1:0] x
  );
`ifdef DESKEW_RELU_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  logic signed [DATA_WIDTH-1:0] row_p1 [N];
  logic [N-1:0]                 vld_p1;

  // Stage p0 -> p1: column c is delayed N-1-c cycles so every lane of a row lines up
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int S = N - 1 - c;
    if (S == 0) begin : g_pass
      assign row_p1[c] = col_data_in[c];
      assign vld_p1[c] = col_valid_in[c];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly_data_p0 [S];
      logic [S-1:0]                 dly_vld_p0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_vld_p0 <= '0;
        end else begin
          dly_vld_p0[0] <= col_valid_in[c];
          for (int i = 1; i < S; i++) dly_vld_p0[i] <= dly_vld_p0[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dly_data_p0[0] <= col_data_in[c];
        for (int i = 1; i < S; i++) dly_data_p0[i] <= dly_data_p0[i-1];
      end

      assign row_p1[c] = dly_data_p0[S-1];
      assign vld_p1[c] = dly_vld_p0[S-1];
    end
  end

  logic signed [DATA_WIDTH-1:0] mem [DEPTH][N];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         row_all, row_any, full, pop, wr_en, ovf_evt, mis_evt;

  assign row_all   = &vld_p1;
  assign row_any   = |vld_p1;
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the row
  assign wr_en     = row_all && (!full || pop);
  assign ovf_evt   = row_all && full && !pop;
  assign mis_evt   = row_any && !row_all;

  // Stage p1 -> FIFO: clamp applied on write, no extra latency
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) mem[wr_ptr][c] <= clamp_lane(row_p1[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error event takes priority over a concurrent clear
      if (ovf_evt)        overflow_err <= 1'b1;
      else if (err_clear) overflow_err <= 1'b0;
      if (mis_evt)        misalign_err <= 1'b1;
      else if (err_clear) misalign_err <= 1'b0;
    end
  end

  assign fifo_count = count;

  always_comb begin
    for (int c = 0; c < N; c++) out_data[c] = out_valid ? mem[rd_ptr][c] : '0;
  end

endmodule

// File: tb/tb_systolic_deskew.sv
// Directed bench for systolic_deskew: per-cycle vector table plus multi-row scheduled sequences.
module tb_systolic_deskew;
  localparam int N = 4, DW = 32, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] col_data_in [N];
  logic                 col_valid_in [N];
  logic signed [DW-1:0] out_data [N];
  logic                 out_valid, out_ready;
  logic [2:0]           fifo_count;
  logic                 overflow_err, misalign_err, err_clear;

  systolic_deskew #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .col_data_in(col_data_in), .col_valid_in(col_valid_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .misalign_err(misalign_err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [3:0] vin;
    int         base;
    bit         rdy;
    bit         clr;
    bit         evld;
    int         ebase;
    int         ecnt;
    bit         eovf;
    bit         emis;
  } vec_t;
  vec_t tbl [18];

  int r_start [8];
  int r_base  [8];
  int nr;
  int pop_lane [$];
  int pop_cyc  [$];
  int cnt_hist [32];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_model(input int v);
`ifdef DESKEW_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk_lanes(input string name, input bit vld, input int base);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s lane%0d", name, c), out_data[c], vld ? lane_model(base + c) : 0);
  endtask

  task automatic chk_pops(input string name, input int nrows, input int base0, input int step);
    chk({name, " pop count"}, pop_lane.size(), nrows * N);
    for (int r = 0; r < nrows && (r + 1) * N <= pop_lane.size(); r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("%s row%0d lane%0d", name, r, c), pop_lane[r*N+c],
            lane_model(base0 + r * step + c));
  endtask

  task automatic zero_inputs();
    for (int c = 0; c < N; c++) begin
      col_valid_in[c] = 1'b0;
      col_data_in[c]  = '0;
    end
  endtask

  task automatic play(input int ncyc, input int rdy_from);
    pop_lane.delete();
    pop_cyc.delete();
    for (int t = 0; t < ncyc; t++) begin
      zero_inputs();
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < N; c++)
          if (t == r_start[r] + c) begin
            col_valid_in[c] = 1'b1;
            col_data_in[c]  = r_base[r] + c;
          end
      out_ready = (t >= rdy_from);
      @(negedge clk);
      if (t < 32) cnt_hist[t] = fifo_count;
      if (out_valid && out_ready) begin
        pop_cyc.push_back(t);
        for (int c = 0; c < N; c++) pop_lane.push_back(out_data[c]);
      end
      @(posedge clk);
      #1;
    end
    zero_inputs();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Single skewed row, then misalignment and clear interplay; vin bit c = column c valid
    tbl[0]  = '{4'b0001, 100, 1, 0, 0,   0, 0, 0, 0};
    tbl[1]  = '{4'b0010, 100, 1, 0, 0,   0, 0, 0, 0};
    tbl[2]  = '{4'b0100, 100, 1, 0, 0,   0, 0, 0, 0};
    tbl[3]  = '{4'b1000, 100, 1, 0, 0,   0, 0, 0, 0};
    tbl[4]  = '{4'b0000,   0, 1, 0, 1, 100, 1, 0, 0};
    tbl[5]  = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 0};
    tbl[6]  = '{4'b0001,  50, 1, 0, 0,   0, 0, 0, 0};
    tbl[7]  = '{4'b0010,  50, 1, 0, 0,   0, 0, 0, 0};
    tbl[8]  = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 0};
    tbl[9]  = '{4'b1100,  50, 1, 0, 0,   0, 0, 0, 0};
    tbl[10] = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 1};
    tbl[11] = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 1};
    tbl[12] = '{4'b0000,   0, 1, 1, 0,   0, 0, 0, 1};
    tbl[13] = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 0};
    tbl[14] = '{4'b1000,   7, 1, 1, 0,   0, 0, 0, 0};
    tbl[15] = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 1};
    tbl[16] = '{4'b0000,   0, 1, 1, 0,   0, 0, 0, 1};
    tbl[17] = '{4'b0000,   0, 1, 0, 0,   0, 0, 0, 0};

    rst = 1'b1;
    out_ready = 1'b0;
    err_clear = 1'b0;
    nr = 0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset overflow_err", overflow_err, 0);
    chk("reset misalign_err", misalign_err, 0);
    chk_lanes("reset out_data", 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      for (int c = 0; c < N; c++) begin
        col_valid_in[c] = tbl[i].vin[c];
        col_data_in[c]  = tbl[i].vin[c] ? tbl[i].base + c : 0;
      end
      out_ready = tbl[i].rdy;
      err_clear = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].evld);
      chk($sformatf("vec%0d fifo_count", i), fifo_count, tbl[i].ecnt);
      chk($sformatf("vec%0d overflow_err", i), overflow_err, tbl[i].eovf);
      chk($sformatf("vec%0d misalign_err", i), misalign_err, tbl[i].emis);
      chk_lanes($sformatf("vec%0d out_data", i), tbl[i].evld, tbl[i].ebase);
      @(posedge clk);
      #1;
    end
    zero_inputs();
    err_clear = 1'b0;
    out_ready = 1'b0;

    // Four rows back-to-back, always ready
    nr = 4;
    for (int r = 0; r < 4; r++) begin r_start[r] = r; r_base[r] = 10 * r; end
    play(12, 0);
    chk_pops("b2b", 4, 0, 10);
    for (int r = 0; r < 4 && r < pop_cyc.size(); r++)
      chk($sformatf("b2b pop cycle row%0d", r), pop_cyc[r], 4 + r);
    chk("b2b overflow_err", overflow_err, 0);
    chk("b2b misalign_err", misalign_err, 0);

    // Five rows into a stalled FIFO: fifth is dropped
    nr = 5;
    for (int r = 0; r < 5; r++) begin r_start[r] = r; r_base[r] = 10 * r; end
    play(10, 99);
    chk("ovf fifo_count", fifo_count, 4);
    chk("ovf overflow_err", overflow_err, 1);
    chk("ovf misalign_err", misalign_err, 0);
    nr = 0;
    play(6, 0);
    chk_pops("ovf drain", 4, 0, 10);
    chk("ovf drained count", fifo_count, 0);
    chk("ovf sticky", overflow_err, 1);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("ovf cleared", overflow_err, 0);

    // Full FIFO with a pop in the same cycle a new row aligns
    nr = 5;
    for (int r = 0; r < 4; r++) begin r_start[r] = r; r_base[r] = 10 * r; end
    r_start[4] = 7;
    r_base[4]  = 40;
    play(18, 10);
    chk("fullpop count c7", cnt_hist[7], 4);
    chk("fullpop count c10", cnt_hist[10], 4);
    chk("fullpop count c11", cnt_hist[11], 4);
    chk("fullpop count c12", cnt_hist[12], 3);
    chk("fullpop overflow_err", overflow_err, 0);
    chk_pops("fullpop", 5, 0, 10);
    if (pop_cyc.size() > 0) chk("fullpop first pop cycle", pop_cyc[0], 10);

    // Negative and mixed-sign lanes through the optional clamp
    nr = 2;
    r_start[0] = 0; r_base[0] = -10;
    r_start[1] = 1; r_base[1] = -2;
    play(8, 0);
    chk_pops("clamp", 2, -10, 8);

    // Reset in the middle of traffic
    col_valid_in[3] = 1'b1;
    @(posedge clk);
    #1;
    zero_inputs();
    nr = 3;
    for (int r = 0; r < 3; r++) begin r_start[r] = r; r_base[r] = 5 + 10 * r; end
    play(5, 99);
    chk("prerst fifo_count", fifo_count, 2);
    chk("prerst misalign_err", misalign_err, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst fifo_count", fifo_count, 0);
    chk("midrst misalign_err", misalign_err, 0);
    chk("midrst overflow_err", overflow_err, 0);
    chk_lanes("midrst out_data", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nr = 0;
    play(10, 0);
    chk("postrst pops", pop_lane.size(), 0);
    chk("postrst fifo_count", fifo_count, 0);
    chk("postrst misalign_err", misalign_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
